// File: rtl/updown_monitor_pkg.sv
// Shared constants and types for the up/down counter monitor.
package updown_monitor_pkg;

  // Event kind codes carried in the event FIFO
  localparam logic [2:0] EV_NONE    = 3'd0;
  localparam logic [2:0] EV_WRAP_UP = 3'd1;
  localparam logic [2:0] EV_WRAP_DN = 3'd2;
  localparam logic [2:0] EV_JUMP    = 3'd3;
  localparam logic [2:0] EV_RISE    = 3'd4;
  localparam logic [2:0] EV_FALL    = 3'd5;

  // Step classification codes driven on dir
  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_JUMP = 2'b11;

  // Hysteresis threshold detector state
  typedef enum logic {
    THR_LOW  = 1'b0,
    THR_HIGH = 1'b1
  } thr_state_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO for monitor events. A push while full is accepted only
// when a pop happens in the same cycle, so a full FIFO can stream at one
// entry per cycle without a bubble. DEPTH must be a power of two, >= 2.
module event_fifo #(
  parameter int DW    = 35,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so the outputs are defined after reset
  assign dout = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards all pending entries
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage write; contents need no reset because empty masks the head
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/updown_monitor.sv
// Passive observer of an up/down counter: classifies every step, runs a
// hysteresis threshold detector and queues notable events for a host.
//
// Event port handshake: event_valid is high whenever the FIFO holds an
// entry; the head (event_kind/event_value) is consumed on a rising clock
// edge where event_valid && event_ready, and it stays stable while
// event_valid && !event_ready. event_valid never depends on event_ready.
module updown_monitor
  import updown_monitor_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] thresh_hi,
  input  logic [WIDTH-1:0] thresh_lo,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [2:0]       event_kind,
  output logic [WIDTH-1:0] event_value,
  output logic [1:0]       dir,
  output logic             overflow,
  input  logic             clear_overflow,
  output logic             thr_state
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] prev;
  logic             prev_valid;
  thr_state_t       state;
  thr_state_t       state_next;
  logic [1:0]       step_cls;
  logic [2:0]       thr_ev;
  logic [2:0]       ev_kind;
  logic             push_req;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  logic [WIDTH+2:0] head;

  assign thr_state = state;

  // Step classification against the previous sample (modular +/-1)
  always_comb begin
    step_cls = DIR_JUMP;
    if (value == prev)            step_cls = DIR_HOLD;
    else if (value == prev + ONE) step_cls = DIR_UP;
    else if (value == prev - ONE) step_cls = DIR_DOWN;
  end

  // Threshold detector: only the compare relevant to the current state
  always_comb begin
    state_next = state;
    thr_ev     = EV_NONE;
    if (state == THR_LOW) begin
      if (value >= thresh_hi) begin
        state_next = THR_HIGH;
        thr_ev     = EV_RISE;
      end
    end else begin
      if (value <= thresh_lo) begin
        state_next = THR_LOW;
        thr_ev     = EV_FALL;
      end
    end
  end

  // Single-event priority select: wrap, then jump, then threshold crossing
  always_comb begin
    ev_kind = EV_NONE;
    if (prev_valid) begin
      if (prev == ALL_ONES && value == '0)      ev_kind = EV_WRAP_UP;
      else if (prev == '0 && value == ALL_ONES) ev_kind = EV_WRAP_DN;
      else if (step_cls == DIR_JUMP)            ev_kind = EV_JUMP;
      else                                      ev_kind = thr_ev;
    end
  end

  assign push_req    = (ev_kind != EV_NONE);
  assign pop         = event_valid && event_ready;
  assign drop        = push_req && fifo_full && !pop;
  assign event_valid = !fifo_empty;
  assign event_kind  = head[WIDTH+2:WIDTH];
  assign event_value = head[WIDTH-1:0];

  // Sample history, step direction, threshold state and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      dir        <= DIR_HOLD;
      state      <= THR_LOW;
      overflow   <= 1'b0;
    end else begin
      prev       <= value;
      prev_valid <= 1'b1;
      if (prev_valid) begin
        dir   <= step_cls;
        state <= state_next;
      end
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  event_fifo #(
    .DW    (WIDTH + 3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .din   ({ev_kind, value}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
